// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage SRAM access unit.
//   - Request enable and operation encodings as latched in the EXE/MEM register.
//   - Access FSM state type.
//   - Data bus width of the pipeline.
package mem_access_pkg;

  localparam int DATA_W    = 16;
  localparam int RAM_EN_W  = 2;
  localparam int RAM_OP_W  = 2;
  localparam int CNT_W     = 4;

  localparam logic [RAM_EN_W-1:0] RAM_EN_OFF   = 2'b00;
  localparam logic [RAM_EN_W-1:0] RAM_EN_ON    = 2'b01;

  localparam logic [RAM_OP_W-1:0] RAM_OP_READ  = 2'b01;
  localparam logic [RAM_OP_W-1:0] RAM_OP_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } mem_state_e;

endpackage

// File: rtl/mem_access_sram_io.sv
// Tri-state pad buffer for the SRAM data bus.
//   drive_en : 1 = drive wdata onto ram_data, 0 = float the bus
//   wdata    : store data to present on the bus
//   rdata    : whatever is currently on the bus (sampled by the FSM on reads)
//   ram_data : bidirectional SRAM data pins
module mem_access_sram_io
  import mem_access_pkg::*;
(
  input  logic              drive_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] ram_data
);

  assign ram_data = drive_en ? wdata : {DATA_W{1'bz}};
  assign rdata    = ram_data;

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs a multi-cycle access on an asynchronous SRAM and stalls the
// pipeline while the access is in flight.
//   clk_50MHz      : stage clock
//   rst            : asynchronous active-low reset
//   em_RAM_en/op   : latched memory request enable / operation
//   em_ALU_data    : access address (zero-extended) or pass-through result
//   em_RAM_WB_data : store data
//   mem_stall      : holds upstream registers while high
//   mem_result     : load data in DONE after a read, else em_ALU_data
//   ram_addr/ram_data/ram_ce_n/ram_oe_n/ram_we_n : SRAM interface
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 1
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic [RAM_EN_W-1:0] em_RAM_en,
  input  logic [RAM_OP_W-1:0] em_RAM_op,
  input  logic [DATA_W-1:0]   em_ALU_data,
  input  logic [DATA_W-1:0]   em_RAM_WB_data,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_result,
  output logic [ADDR_W-1:0]   ram_addr,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                last_rd_q, last_rd_d;

  logic                is_read;
  logic                is_write;
  logic                req;
  logic                drive_en;
  logic [DATA_W-1:0]   bus_rdata;

  assign is_read  = (em_RAM_en == RAM_EN_ON) && (em_RAM_op == RAM_OP_READ);
  assign is_write = (em_RAM_en == RAM_EN_ON) && (em_RAM_op == RAM_OP_WRITE);
  assign req      = is_read || is_write;

  mem_access_sram_io u_sram_io (
    .drive_en (drive_en),
    .wdata    (wdata_q),
    .rdata    (bus_rdata),
    .ram_data (ram_data)
  );

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    last_rd_d = last_rd_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = {{(ADDR_W-DATA_W){1'b0}}, em_ALU_data};
          wdata_d   = em_RAM_WB_data;
          last_rd_d = is_read;
          cnt_d     = '0;
          state_d   = is_read ? S_RD : S_WR_SETUP;
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = bus_rdata;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_HOLD: state_d = S_DONE;
      // Always return to IDLE so the still-latched request is not restarted.
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // releases WE and the bus in the same cycle.
  always_comb begin
    ram_ce_n  = 1'b1;
    ram_oe_n  = 1'b1;
    ram_we_n  = 1'b1;
    drive_en  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE:     mem_stall = req;
      S_RD: begin
        ram_ce_n  = 1'b0;
        ram_oe_n  = 1'b0;
        mem_stall = 1'b1;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ram_ce_n  = 1'b0;
        drive_en  = 1'b1;
        mem_stall = 1'b1;
      end
      S_WR_PULSE: begin
        ram_ce_n  = 1'b0;
        ram_we_n  = 1'b0;
        drive_en  = 1'b1;
        mem_stall = 1'b1;
      end
      default: ;
    endcase
    // A request may still be present while reset is held; never stall then.
    if (!rst) mem_stall = 1'b0;
  end

  assign ram_addr   = addr_q;
  assign mem_result = (state_q == S_DONE && last_rd_q) ? rdata_q : em_ALU_data;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  em_RAM_en = 2'b00;
  logic [1:0]  em_RAM_op = 2'b00;
  logic [15:0] em_ALU_data = 16'h1111;
  logic [15:0] em_RAM_WB_data = 16'h0000;
  logic        mem_stall;
  logic [15:0] mem_result;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_ce_n, ram_oe_n, ram_we_n;

  mem_access #(.ADDR_W(18), .RD_WAIT(2), .WR_PULSE(1)) dut (
    .clk_50MHz      (clk_50MHz),
    .rst            (rst),
    .em_RAM_en      (em_RAM_en),
    .em_RAM_op      (em_RAM_op),
    .em_ALU_data    (em_ALU_data),
    .em_RAM_WB_data (em_RAM_WB_data),
    .mem_stall      (mem_stall),
    .mem_result     (mem_result),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .ram_ce_n       (ram_ce_n),
    .ram_oe_n       (ram_oe_n),
    .ram_we_n       (ram_we_n)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Asynchronous SRAM model (1K words).
  logic [15:0] mem [0:1023];
  logic        sram_drv;
  assign sram_drv = !ram_ce_n && !ram_oe_n && ram_we_n;
  assign ram_data = sram_drv ? mem[ram_addr[9:0]] : 16'hzzzz;
  always @(negedge clk_50MHz)
    if (!ram_ce_n && !ram_we_n) mem[ram_addr[9:0]] <= ram_data;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    int          stall;
    int          oe;
    int          we;
    logic [17:0] addr;
    int          drv;
    logic [15:0] wd;
  } exp_t;

  exp_t q[$];
  logic mon_en = 1'b0;
  int   done_cnt = 0;
  int   st_c = 0, oe_c = 0, we_c = 0, drv_c = 0;
  logic ovl = 1'b0;
  logic [17:0] addr_seen = '0;
  logic [15:0] drv_v = '0;

  // Monitor: a non-stalled cycle is the stage presenting its result.
  always @(negedge clk_50MHz) begin
    if (!mon_en || q.size() == 0) begin
      st_c = 0; oe_c = 0; we_c = 0; drv_c = 0; ovl = 1'b0;
    end else begin
      if (!ram_oe_n) oe_c++;
      if (!ram_we_n) we_c++;
      if (!ram_oe_n && !ram_we_n) ovl = 1'b1;
      if (!ram_oe_n || !ram_we_n) addr_seen = ram_addr;
      if (!ram_ce_n && ram_oe_n && ram_we_n) begin
        drv_c++;
        drv_v = ram_data;
      end
      if (mem_stall) st_c++;
      else begin
        exp_t e;
        e = q.pop_front();
        chk("mem_result", 32'(mem_result), 32'(e.res));
        chk("stall_cycles", st_c, e.stall);
        chk("oe_low_cycles", oe_c, e.oe);
        chk("we_low_cycles", we_c, e.we);
        chk("we_oe_overlap", 32'(ovl), 32'd0);
        chk("drive_window_cycles", drv_c, e.drv);
        if (e.oe + e.we > 0) chk("ram_addr", 32'(addr_seen), 32'(e.addr));
        if (e.drv > 0) chk("write_data_on_bus", 32'(drv_v), 32'(e.wd));
        st_c = 0; oe_c = 0; we_c = 0; drv_c = 0; ovl = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [1:0] en, input logic [1:0] op,
                       input logic [15:0] alu, input logic [15:0] wd, input exp_t e);
    int start;
    bit seen;
    @(posedge clk_50MHz); #1;
    em_RAM_en = en; em_RAM_op = op; em_ALU_data = alu; em_RAM_WB_data = wd;
    start = done_cnt;
    q.push_back(e);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_50MHz); #1;
      if (done_cnt != start) seen = 1;
    end
    if (!seen) begin
      chk("access_timeout", 32'd0, 32'd1);
      q.delete();
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input int stall, input int oe,
                              input int we, input logic [17:0] addr, input int drv,
                              input logic [15:0] wd);
    exp_t e;
    e.res = res; e.stall = stall; e.oe = oe; e.we = we;
    e.addr = addr; e.drv = drv; e.wd = wd;
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h234] = 16'hBEEF;
    mem[10'h3FF] = 16'h5A5A;

    // Reset state
    #5;
    chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_result", 32'(mem_result), 32'h1111);
    #20 rst = 1'b1;
    mon_en = 1'b1;

    // Pass-through: enable off, then enable on with undefined ops
    issue(2'b00, 2'b01, 16'h7F00, 16'h0, mk(16'h7F00, 0, 0, 0, 18'h0, 0, 16'h0));
    issue(2'b01, 2'b11, 16'h7F00, 16'h0, mk(16'h7F00, 0, 0, 0, 18'h0, 0, 16'h0));
    issue(2'b01, 2'b00, 16'h3C3C, 16'h0, mk(16'h3C3C, 0, 0, 0, 18'h0, 0, 16'h0));

    // Read 0x1234 -> 0xBEEF
    issue(2'b01, 2'b01, 16'h1234, 16'h0, mk(16'hBEEF, 3, 2, 0, 18'h01234, 0, 16'h0));
    // Read top of 16-bit address space: zero-extended
    issue(2'b01, 2'b01, 16'hFFFF, 16'h0, mk(16'h5A5A, 3, 2, 0, 18'h0FFFF, 0, 16'h0));

    // Write 0xA5A5 to 0x0040; result is ALU pass-through
    issue(2'b01, 2'b10, 16'h0040, 16'hA5A5, mk(16'h0040, 4, 0, 1, 18'h00040, 2, 16'hA5A5));
    chk("sram_0040", 32'(mem[10'h040]), 32'h0000A5A5);

    // Back-to-back write then read of the same location
    issue(2'b01, 2'b10, 16'h0010, 16'h0001, mk(16'h0010, 4, 0, 1, 18'h00010, 2, 16'h0001));
    issue(2'b01, 2'b01, 16'h0010, 16'h0, mk(16'h0001, 3, 2, 0, 18'h00010, 0, 16'h0));

    // Reset asserted in the middle of a write pulse
    mon_en = 1'b0;
    @(posedge clk_50MHz); #1;
    em_RAM_en = 2'b01; em_RAM_op = 2'b10; em_ALU_data = 16'h0020; em_RAM_WB_data = 16'h1357;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
        @(negedge clk_50MHz);
        if (!ram_we_n) hit = 1;
      end
      chk("reached_wr_pulse", 32'(hit), 32'd1);
    end
    #3 rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(ram_we_n), 32'd1);
    chk("abort_ce_n", 32'(ram_ce_n), 32'd1);
    chk("abort_oe_n", 32'(ram_oe_n), 32'd1);
    chk("abort_stall", 32'(mem_stall), 32'd0);
    chk("abort_addr", 32'(ram_addr), 32'd0);
    em_RAM_en = 2'b00;
    #20 rst = 1'b1;
    mon_en = 1'b1;

    // Recovery after reset
    issue(2'b01, 2'b01, 16'h1234, 16'h0, mk(16'hBEEF, 3, 2, 0, 18'h01234, 0, 16'h0));
    issue(2'b00, 2'b00, 16'h00AA, 16'h0, mk(16'h00AA, 0, 0, 0, 18'h0, 0, 16'h0));

    @(posedge clk_50MHz); #1;
    em_RAM_en = 2'b00;
    repeat (2) @(posedge clk_50MHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage unit, directly downstream of the EXE/MEM pipeline register.
- Consumes the latched memory enable/op, ALU result (used as address) and store data, and runs a multi-cycle access on the external asynchronous SRAM.
- Stalls the pipeline for the duration of the access and presents the stage result (load data or ALU pass-through) to the MEM/WB register.

Parameters:
- ADDR_W, 18, SRAM address width; the 16-bit ALU address is zero-extended into it.
- RD_WAIT, 2, cycles OE/CE are held low before read data is captured (1..15).
- WR_PULSE, 1, cycles WE is held low (1..15).

Ports:
- clk_50MHz  in  1  stage clock.
- rst  in  1  asynchronous active-low reset.
- em_RAM_en  in  `RAM_EN_OP_BUS  memory request enable; `RAM_EN_ON = access, anything else = none.
- em_RAM_op  in  `RAM_OP_BUS  `RAM_OP_READ or `RAM_OP_WRITE.
- em_ALU_data  in  `DATA_BUS  access address / pass-through result.
- em_RAM_WB_data  in  `DATA_BUS  store data.
- mem_stall  out  1  hold PC/IF_ID/ID_EXE/EXE_MEM and bubble MEM/WB while high.
- mem_result  out  `DATA_BUS  load data on a completed read, else em_ALU_data.
- ram_addr  out  ADDR_W  SRAM address.
- ram_data  inout  `DATA_BUS  SRAM data; high-Z unless writing.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, captured data=0.
  - ram_ce_n=ram_oe_n=ram_we_n=1, ram_addr=0, ram_data=Z.
  - mem_stall=0.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- req = (em_RAM_en==`RAM_EN_ON) and op is READ or WRITE. An undefined op with en on is a no-op: no stall, ALU pass-through.
- IDLE:
  - Strobes high, bus Z.
  - On req, go to RD (read) or WR_SETUP (write). Address and write data are registered at this edge.
- RD:
  - ce_n=oe_n=0; counter counts RD_WAIT cycles.
  - On the last RD edge, sample ram_data into the capture register and go to DONE.
- WR_SETUP: ce_n=0, we_n=1, address and data driven; 1 cycle.
- WR_PULSE: we_n=0, address and data held; WR_PULSE cycles.
- WR_HOLD: we_n=1, ce_n=0, data still driven (hold time); 1 cycle, then DONE.
- DONE:
  - Strobes high, bus Z. mem_stall=0, so the pipeline advances at this edge.
  - Next state is always IDLE, so the same request is never restarted.
- mem_stall is combinational:
  - 1 in IDLE when req is present.
  - 1 in RD, WR_SETUP, WR_PULSE and WR_HOLD.
  - 0 otherwise.
- Stall cycles per access: read = RD_WAIT+1; write = WR_PULSE+3.
- Back-to-back memory ops: the following op lands in EXE_MEM at the DONE edge and is seen in IDLE the next cycle. This gives one non-stalled DONE cycle between accesses.
- mem_result:
  - Equals the capture register in DONE when the access was a read.
  - Otherwise equals em_ALU_data (combinational).
- Bus safety: ram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. we_n and oe_n are never both low.
- Address is {zero pad, em_ALU_data}, latched at request acceptance and stable for the whole access.
- Reset mid-access aborts immediately: we_n deasserts asynchronously and the bus floats. No partial-write guarantee.
- em_* changes during a stall are ignored; the inputs are held upstream anyway.

Decomposition:
- Shared package (define.v): `RAM_EN_ON/`RAM_EN_OFF, `RAM_OP_READ/`RAM_OP_WRITE, `MEM_STATE_BUS and the six state encodings, `SRAM_ADDR_BUS.
- Natural sub-module: sram_io.
  - Tri-state buffer for ram_data: drive enable plus write data in, sampled read data out.
  - Keeps the inout out of the FSM and eases synthesis on the board pads.

Test Plan:
- Reset: assert rst=0 mid-WR_PULSE -> we_n=1 and ram_data=Z within the same cycle; state IDLE; mem_stall=0.
- Read, RD_WAIT=2: en on, READ, addr 0x1234, SRAM model returns 0xBEEF -> ram_addr=0x01234; oe_n low for 2 cycles; mem_stall high for 3 cycles; mem_result=0xBEEF in DONE.
- Write, WR_PULSE=1: WRITE, addr 0x0040, data 0xA5A5 -> model holds 0xA5A5 at 0x0040; we_n low exactly 1 cycle, with data driven 1 cycle before and after; mem_stall high for 4 cycles.
- Back-to-back: write 0x0001 to 0x0010, then read 0x0010 -> one DONE gap between accesses; read returns 0x0001; no overlap of we_n and oe_n.
- No-op/pass-through: en off, em_ALU_data=0x7F00 -> mem_stall=0; strobes high; mem_result=0x7F00 in the same cycle. Repeat with en on and an undefined op -> same result.
